qdec: RTL and testbench

QDEC -- requirements
Module: qdec

---
 rtl/qdec.sv | 114 +++++++++++
 tb/tb_qdec.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/qdec.sv
// Quadrature decoder: synchronised A/B/Z inputs, signed position counter, step pulse, sticky error.
// Define QDEC_ZRESET_EN to build the index (Z) zeroing feature; otherwise z_i and RST_ON_Z are ignored.
module qdec #(
  parameter int POSN_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              a_i,
  input  logic              b_i,
  input  logic              z_i,
  input  logic [POSN_W-1:0] SETP,
  input  logic              setp_wstb_i,
  input  logic              DIR,
  input  logic              RST_ON_Z,
  output logic [POSN_W-1:0] posn_o,
  output logic              step_o,
  output logic              err_o
);

  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic [1:0]             ab_cur, ab_prev_q;
  logic [2:0]             warm_q;
  logic                   armed;
  logic [POSN_W-1:0]      posn_q, posn_d;
  logic                   step_q, step_d;
  logic                   err_q, err_d;
  logic                   mv_legal, mv_up, mv_illegal;
  logic                   zero_req;

  assign ab_cur = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
  // Counting waits until the synchroniser has refilled after reset and the
  // stored pair has been loaded once from it, so a non-00 rest state is silent.
  assign armed  = (warm_q == WARM_DONE);

`ifdef QDEC_ZRESET_EN
  logic [SYNC_STAGES-1:0] z_sync_q;
  logic                   z_prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      z_sync_q <= '0;
      z_prev_q <= 1'b0;
    end else begin
      z_sync_q <= {z_sync_q[SYNC_STAGES-2:0], z_i};
      z_prev_q <= z_sync_q[SYNC_STAGES-1];
    end
  end

  assign zero_req = armed && RST_ON_Z && z_sync_q[SYNC_STAGES-1] && !z_prev_q;
`else
  logic unused_z;
  assign unused_z = z_i ^ RST_ON_Z;
  assign zero_req = 1'b0;
`endif

  always_comb begin
    mv_legal   = 1'b0;
    mv_up      = 1'b0;
    mv_illegal = 1'b0;
    case ({ab_prev_q, ab_cur})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
        mv_legal = 1'b1;
        mv_up    = 1'b1;
      end
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: mv_legal   = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: mv_illegal = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    posn_d = posn_q;
    step_d = 1'b0;
    err_d  = err_q;
    if (armed && mv_illegal) err_d = 1'b1;
    if (setp_wstb_i) begin
      posn_d = SETP;
      err_d  = 1'b0;
    end else if (zero_req) begin
      posn_d = '0;
    end else if (armed && mv_legal) begin
      posn_d = (mv_up ^ DIR) ? posn_q + POSN_W'(1) : posn_q - POSN_W'(1);
      step_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_sync_q  <= '0;
      b_sync_q  <= '0;
      ab_prev_q <= '0;
      warm_q    <= '0;
      posn_q    <= '0;
      step_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      a_sync_q  <= {a_sync_q[SYNC_STAGES-2:0], a_i};
      b_sync_q  <= {b_sync_q[SYNC_STAGES-2:0], b_i};
      ab_prev_q <= ab_cur;
      if (!armed) warm_q <= warm_q + 3'd1;
      posn_q    <= posn_d;
      step_q    <= step_d;
      err_q     <= err_d;
    end
  end

  assign posn_o = posn_q;
  assign step_o = step_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_qdec.sv
// Directed self-checking bench for qdec (SYNC_STAGES=2, POSN_W=32).
module tb_qdec;

  logic        clk = 1'b0;
  logic        reset_i, a_i, b_i, z_i, setp_wstb_i, DIR, RST_ON_Z;
  logic [31:0] SETP;
  logic [31:0] posn_o;
  logic        step_o, err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int step_total = 0;
  int step_snap;

  logic [1:0] lag_seq [4];

  qdec #(.POSN_W(32), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .reset_i(reset_i), .a_i(a_i), .b_i(b_i), .z_i(z_i),
    .SETP(SETP), .setp_wstb_i(setp_wstb_i), .DIR(DIR), .RST_ON_Z(RST_ON_Z),
    .posn_o(posn_o), .step_o(step_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (step_o === 1'b1) step_total++;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ab(input logic [1:0] v);
    a_i = v[1];
    b_i = v[0];
  endtask

  task automatic load(input logic [31:0] v);
    SETP = v;
    setp_wstb_i = 1'b1;
    tick();
    setp_wstb_i = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    lag_seq[0] = 2'b01; lag_seq[1] = 2'b11; lag_seq[2] = 2'b10; lag_seq[3] = 2'b00;
    reset_i = 1'b1; a_i = 1'b0; b_i = 1'b0; z_i = 1'b0;
    SETP = '0; setp_wstb_i = 1'b0; DIR = 1'b0; RST_ON_Z = 1'b0;

    tick(125);
    check("rst_posn", posn_o, 0);
    check("rst_step", step_o, 0);
    check("rst_err",  err_o,  0);
    reset_i = 1'b0;
    tick(5);

    // Long run of A-lags-B steps from a preload of 5000
    load(32'd5000);
    check("setp_5000", posn_o, 5000);
    step_snap = step_total;
    for (int i = 0; i < 1200; i++) begin
      set_ab(lag_seq[i % 4]);
      tick(20);
    end
    tick(5);
    check("run_posn",  posn_o, 3800);
    check("run_steps", step_total - step_snap, 1200);
    check("run_err",   err_o, 0);

    // Wrap-around both ways
    load(32'h7FFF_FFFF);
    set_ab(2'b10);
    tick(5);
    check("wrap_up", posn_o, 32'h8000_0000);
    check("wrap_up_err", err_o, 0);
    load(32'd0);
    set_ab(2'b00);
    tick(5);
    check("wrap_dn", posn_o, 32'hFFFF_FFFF);

    // Latency: a_i edge in cycle N visible at N+3 only
    load(32'd10);
    tick(2);
    set_ab(2'b10);
    tick();
    check("lat1_posn", posn_o, 10);
    check("lat1_step", step_o, 0);
    tick();
    check("lat2_posn", posn_o, 10);
    check("lat2_step", step_o, 0);
    tick();
    check("lat3_posn", posn_o, 11);
    check("lat3_step", step_o, 1);
    tick();
    check("lat4_posn", posn_o, 11);
    check("lat4_step", step_o, 0);

    // DIR change alone does not move the count; next step is inverted
    DIR = 1'b1;
    tick(5);
    check("dir_hold", posn_o, 11);
    set_ab(2'b11);
    tick(5);
    check("dir_inv", posn_o, 10);
    DIR = 1'b0;
    set_ab(2'b01);
    tick(5);
    set_ab(2'b00);
    tick(5);
    check("dir_back", posn_o, 12);

    // Illegal double change, sticky error, cleared by preload
    set_ab(2'b11);
    tick(6);
    check("ill_posn", posn_o, 12);
    check("ill_err",  err_o, 1);
    set_ab(2'b10);
    tick(6);
    check("sticky_posn", posn_o, 11);
    check("sticky_err",  err_o, 1);
    load(32'd100);
    check("clr_posn", posn_o, 100);
    check("clr_err",  err_o, 0);

    // Index edge coincident with a legal step
    load(32'd4321);
    RST_ON_Z = 1'b1;
    tick(2);
    set_ab(2'b11);
    z_i = 1'b1;
    tick(3);
`ifdef QDEC_ZRESET_EN
    check("zrst_posn", posn_o, 0);
    check("zrst_step", step_o, 0);
`else
    check("zign_posn", posn_o, 4322);
    check("zign_step", step_o, 1);
`endif
    z_i = 1'b0;
    tick(5);
    RST_ON_Z = 1'b0;
    load(32'd4321);
    tick(2);
    set_ab(2'b01);
    z_i = 1'b1;
    tick(3);
    check("zoff_posn", posn_o, 4322);
    check("zoff_step", step_o, 1);
    z_i = 1'b0;
    tick(5);

    // Reset during an in-flight edge discards it
    step_snap = step_total;
    set_ab(2'b00);
    tick();
    reset_i = 1'b1;
    tick(3);
    reset_i = 1'b0;
    tick(10);
    check("midrst_posn",  posn_o, 0);
    check("midrst_steps", step_total - step_snap, 0);
    check("midrst_err",   err_o, 0);

    // Release reset while resting at 11
    reset_i = 1'b1;
    set_ab(2'b11);
    tick(3);
    reset_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("rest11", {posn_o, step_o, err_o}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
